// File: rtl/mul_div_seq_unit.sv
// Sequential RV32M multiply/divide unit: radix-2 shift-add multiplier and
// restoring divider sharing one 2*XLEN accumulator, with busy/ready handshake.
module mul_div_seq_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            abort,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            ready
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  typedef struct packed {
    logic [2:0] op;
    logic       neg_q;   // negate product / quotient
    logic       neg_r;   // negate remainder (dividend was negative)
  } ctx_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [2*XLEN-1:0] acc, acc_nxt;
  logic [XLEN-1:0]   opnd, opnd_nxt;   // |multiplicand| or |divisor|
  ctx_t              ctx, ctx_nxt;
  logic [XLEN-1:0]   result_nxt;

  // Operand decode at accept time
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, special_res;
  logic            div_zero, div_ovf, accept;

  assign b_sgn = (op == 3'd1) | (op[2] & ~op[0]);
  assign a_sgn = b_sgn | (op == 3'd2);
  assign a_neg = a_sgn & operand_a[XLEN-1];
  assign b_neg = b_sgn & operand_b[XLEN-1];
  assign a_mag = a_neg ? -operand_a : operand_a;
  assign b_mag = b_neg ? -operand_b : operand_b;

  assign div_zero = op[2] & (operand_b == '0);
  assign div_ovf  = op[2] & ~op[0] & (operand_a == MIN_NEG) & (operand_b == '1);
  always_comb begin
    special_res = '1;
    if (div_zero)     special_res = op[1] ? operand_a : '1;
    else if (div_ovf) special_res = op[1] ? '0 : operand_a;
  end

  assign accept = start & ~abort & ((state == S_IDLE) | (state == S_DONE));

  // One iteration of each algorithm
  logic [XLEN:0]     mul_sum, rem_sh;
  logic [XLEN-1:0]   rem_sub;
  logic              no_borrow;
  logic [2*XLEN-1:0] mul_step, div_step, fin, fin_neg;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_step = {mul_sum, acc[XLEN-1:1]};

  // Remainder after the shift can reach XLEN+1 bits; the difference never does.
  assign rem_sh    = acc[2*XLEN-1:XLEN-1];
  assign no_borrow = rem_sh >= {1'b0, opnd};
  assign rem_sub   = rem_sh[XLEN-1:0] - opnd;
  assign div_step  = no_borrow ? {rem_sub, acc[XLEN-2:0], 1'b1}
                               : {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};

  // Sign fixup is folded into the final iteration so result is valid in DONE.
  assign fin     = (state == S_MUL) ? mul_step : div_step;
  assign fin_neg = -fin;

  logic [XLEN-1:0] quo_f, rem_f, res_fin;
  assign quo_f = ctx.neg_q ? -fin[XLEN-1:0] : fin[XLEN-1:0];
  assign rem_f = ctx.neg_r ? -fin[2*XLEN-1:XLEN] : fin[2*XLEN-1:XLEN];

  always_comb begin
    res_fin = rem_f;
    case (ctx.op)
      3'd0:             res_fin = ctx.neg_q ? fin_neg[XLEN-1:0] : fin[XLEN-1:0];
      3'd1, 3'd2, 3'd3: res_fin = ctx.neg_q ? fin_neg[2*XLEN-1:XLEN] : fin[2*XLEN-1:XLEN];
      3'd4, 3'd5:       res_fin = quo_f;
      default:          res_fin = rem_f;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    acc_nxt    = acc;
    opnd_nxt   = opnd;
    ctx_nxt    = ctx;
    result_nxt = result;
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (accept) begin
          ctx_nxt = '{op: op, neg_q: a_neg ^ b_neg, neg_r: a_neg};
          cnt_nxt = CW'(XLEN);
          if (div_zero | div_ovf) begin
            state_nxt  = S_DONE;
            result_nxt = special_res;
          end else if (op[2]) begin
            state_nxt = S_DIV;
            acc_nxt   = {{XLEN{1'b0}}, a_mag};
            opnd_nxt  = b_mag;
          end else begin
            state_nxt = S_MUL;
            acc_nxt   = {{XLEN{1'b0}}, b_mag};
            opnd_nxt  = a_mag;
          end
        end
      end
      S_MUL, S_DIV: begin
        acc_nxt = (state == S_MUL) ? mul_step : div_step;
        cnt_nxt = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state_nxt  = S_DONE;
          result_nxt = res_fin;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt  = S_IDLE;
      result_nxt = result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      ctx    <= '0;
      result <= '0;
    end else begin
      cnt    <= cnt_nxt;
      acc    <= acc_nxt;
      opnd   <= opnd_nxt;
      ctx    <= ctx_nxt;
      result <= result_nxt;
    end
  end

  assign busy  = (state == S_MUL) | (state == S_DIV);
  assign ready = (state == S_DONE);

endmodule

// File: tb/tb_mul_div_seq_unit.sv
// Bench for mul_div_seq_unit: vector table + random ops against a 64-bit
// reference model, scoreboard on ready, and hand-written handshake sequences.
module tb_mul_div_seq_unit;
  localparam int XLEN = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 0;
  logic        reset, start, abort;
  logic [2:0]  op;
  logic [31:0] operand_a, operand_b, result;
  logic        busy, ready;

  mul_div_seq_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .abort(abort),
    .result(result), .busy(busy), .ready(ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] sbq[$];
  logic [31:0] sb_exp;
  logic [31:0] last_res;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: ready with result %h, none expected", result);
      end else begin
        sb_exp = sbq.pop_front();
        if (result !== sb_exp) begin
          bad++;
          $display("FAIL sb_result: got %h want %h", result, sb_exp);
        end
      end
    end
  end

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    za  = {32'b0, a};
    zb  = {32'b0, b};
    ovf = (a == MIN) && (b == 32'hffff_ffff);
    case (o)
      3'd0: begin p = za * zb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * zb; return p[63:32]; end
      3'd3: begin p = za * zb; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hffff_ffff : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hffff_ffff : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic add(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.exp = e;
    vecs.push_back(v);
  endtask

  // Called #1 after an edge with the unit idle; returns #1 after the edge
  // following the ready cycle.
  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e);
    int n;
    bit bz, sp;
    sp = o[2] && ((b == 0) || (!o[0] && a == MIN && b == 32'hffff_ffff));
    start = 1; op = o; operand_a = a; operand_b = b;
    sbq.push_back(e);
    @(posedge clk); #1;
    start = 0; n = 1; bz = 1;
    while (ready !== 1'b1 && n < 100) begin
      if (busy !== 1'b1) bz = 0;
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, n, sp ? 32'd1 : 32'(XLEN + 1));
    chk({nm, "_busy"}, {31'b0, bz && (busy === 1'b0)}, 32'd1);
    last_res = e;
    @(posedge clk); #1;
    chk({nm, "_pulse"}, {31'b0, ready}, 32'd0);
  endtask

  task automatic wait_ready(input int limit, inout int n);
    while (ready !== 1'b1 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int n;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    reset = 1; start = 0; abort = 0; op = 0; operand_a = 0; operand_b = 0;
    last_res = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_ready", {31'b0, ready}, 0);
    chk("rst_result", result, 0);
    reset = 0;
    @(posedge clk); #1;

    add(3'd0, 32'd7,          32'd6,          32'd42);
    add(3'd3, 32'hffff_ffff,  32'hffff_ffff,  32'hffff_fffe);
    add(3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000);
    add(3'd2, 32'hffff_ffff,  32'd2,          32'hffff_ffff);
    add(3'd0, 32'hffff_fffd,  32'd5,          32'hffff_fff1);
    add(3'd1, 32'hffff_fffd,  32'd5,          32'hffff_ffff);
    add(3'd3, 32'h8000_0000,  32'd2,          32'd1);
    add(3'd0, 32'h1234_5678,  32'd16,         32'h2345_6780);
    add(3'd4, 32'hffff_fff9,  32'd2,          32'hffff_fffd);
    add(3'd6, 32'hffff_fff9,  32'd2,          32'hffff_ffff);
    add(3'd4, 32'd7,          32'hffff_fffe,  32'hffff_fffd);
    add(3'd6, 32'd7,          32'hffff_fffe,  32'd1);
    add(3'd5, 32'd100,        32'd7,          32'd14);
    add(3'd7, 32'd100,        32'd7,          32'd2);
    add(3'd5, 32'hffff_ffff,  32'd1,          32'hffff_ffff);
    add(3'd4, 32'd5,          32'd0,          32'hffff_ffff);
    add(3'd6, 32'd5,          32'd0,          32'd5);
    add(3'd5, 32'd5,          32'd0,          32'hffff_ffff);
    add(3'd7, 32'd5,          32'd0,          32'd5);
    add(3'd4, 32'h8000_0000,  32'hffff_ffff,  32'h8000_0000);
    add(3'd6, 32'h8000_0000,  32'hffff_ffff,  32'd0);
    add(3'd5, 32'h8000_0000,  32'hffff_ffff,  32'd0);
    add(3'd7, 32'h8000_0000,  32'hffff_ffff,  32'h8000_0000);

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    for (int i = 0; i < 12; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
      run_op($sformatf("rnd%0d", i), ro, ra, rb, model(ro, ra, rb));
    end

    // Abort at cycle 10 of a DIVU: nothing completes, result untouched.
    start = 1; op = 3'd5; operand_a = 32'd1000; operand_b = 32'd3;
    @(posedge clk); #1;
    start = 0;
    repeat (9) @(posedge clk);
    #1;
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_ready", {31'b0, ready}, 0);
    chk("abort_result", result, last_res);
    repeat (40) @(posedge clk);
    #1;
    chk("abort_idle_result", result, last_res);

    // A start pulse mid-operation is ignored.
    start = 1; op = 3'd0; operand_a = 32'd7; operand_b = 32'd6;
    sbq.push_back(32'd42);
    @(posedge clk); #1;
    start = 0; n = 1;
    repeat (4) begin @(posedge clk); #1; n++; end
    start = 1; op = 3'd5; operand_a = 32'd9; operand_b = 32'd3;
    @(posedge clk); #1; n++;
    start = 0;
    wait_ready(100, n);
    chk("ign_lat", n, 33);
    chk("ign_result", result, 32'd42);
    @(posedge clk); #1;

    // Back-to-back with start held through DONE.
    start = 1; op = 3'd0; operand_a = 32'd3; operand_b = 32'd3;
    sbq.push_back(32'd9); sbq.push_back(32'd16);
    @(posedge clk); #1;
    operand_a = 32'd4; operand_b = 32'd4;
    n = 1;
    wait_ready(100, n);
    chk("b2b_lat1", n, 33);
    @(posedge clk); #1; n++;
    start = 0;
    chk("b2b_busy", {31'b0, busy}, 1);
    wait_ready(200, n);
    chk("b2b_lat2", n, 66);
    chk("b2b_result", result, 32'd16);
    @(posedge clk); #1;

    // Abort during DONE: ready seen, but the held start is not taken.
    start = 1; op = 3'd0; operand_a = 32'd2; operand_b = 32'd5;
    sbq.push_back(32'd10);
    @(posedge clk); #1;
    n = 1;
    wait_ready(100, n);
    chk("abdone_lat", n, 33);
    abort = 1;
    @(posedge clk); #1;
    abort = 0; start = 0;
    chk("abdone_busy", {31'b0, busy}, 0);
    chk("abdone_ready", {31'b0, ready}, 0);
    chk("abdone_result", result, 32'd10);

    // abort + start together in IDLE starts nothing.
    start = 1; abort = 1; op = 3'd4; operand_a = 32'd5; operand_b = 32'd0;
    @(posedge clk); #1;
    start = 0; abort = 0;
    chk("abst_busy", {31'b0, busy}, 0);
    chk("abst_ready", {31'b0, ready}, 0);
    chk("abst_result", result, 32'd10);

    // Reset mid-operation clears all outputs.
    start = 1; op = 3'd1; operand_a = 32'd123; operand_b = 32'd456;
    @(posedge clk); #1;
    start = 0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk); #1;
    chk("mrst_busy", {31'b0, busy}, 0);
    chk("mrst_ready", {31'b0, ready}, 0);
    chk("mrst_result", result, 0);
    reset = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
